// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 device-to-host receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a; the receive path has no ready input and never stalls.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  // PS/2 uses odd parity: data bits plus the parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(logic [7:0] d, logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronizes ps2_clk/ps2_data, glitch-filters the clock and flags its falling edges.
// Latency: SYNC_STAGES cycles of synchronization, then FILTER_LEN cycles of filtering before fall.
// Backpressure: none; fall is a free-running one-cycle pulse.
// Ports: clk/reset (sync, active-high); ps2_clk/ps2_data async pad inputs;
//        fall = filtered clock went 1->0 this cycle; data_s = synchronized ps2_data.
module ps2_clk_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_s
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_f;
  logic [CW-1:0]          cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_f     <= 1'b1;
      cnt       <= '0;
      fall      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      fall      <= 1'b0;
      // cnt counts consecutive samples disagreeing with clk_f; any agreeing sample restarts it.
      if (clk_sync[SYNC_STAGES-1] != clk_f) begin
        if (cnt == CNT_LAST) begin
          clk_f <= ~clk_f;
          cnt   <= '0;
          fall  <= clk_f;  // clk_f was 1, so this toggle is a falling edge
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign data_s = data_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_rx_deserializer.sv
// Turns PS/2 11-bit device-to-host frames into bytes with parity/stop/timeout checking.
// Latency: strobes register 1 clk after the cycle that sees the stop-bit fall.
// Backpressure: none; byte_valid/parity_err/frame_err are one-cycle strobes the consumer must take.
// Ports: clk/reset (sync, active-high); ps2_clk/ps2_data async pads;
//        byte_out = last good byte; byte_valid, parity_err, frame_err = one-cycle strobes.
module ps2_rx_deserializer
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_RELOAD = TW'(TIMEOUT_CYCLES);
  localparam logic [2:0]    LAST_BIT   = 3'(PS2_DATA_BITS - 1);

  logic                     fall;
  logic                     data_s;
  rx_state_t                state;
  rx_state_t                state_n;
  logic [2:0]               bit_cnt;
  logic [PS2_DATA_BITS-1:0] shreg;
  logic                     par_bit;
  logic [TW-1:0]            tmo;
  logic                     timeout;
  logic                     frame_done;
  logic                     par_ok;
  logic                     stop_ok;

  ps2_clk_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_filter (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (data_s_in_unused_guard(ps2_data)),
    .fall     (fall),
    .data_s   (data_s)
  );

  function automatic logic data_s_in_unused_guard(logic d);
    return d;
  endfunction

  // During STOP, data_s on the fall is the stop bit itself.
  assign par_ok  = odd_parity_ok(shreg, par_bit);
  assign stop_ok = data_s;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    frame_done = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (fall && !data_s) state_n = DATA;
      end
      DATA: begin
        if (fall) begin
          if (bit_cnt == LAST_BIT) state_n = PARITY;
        end else if (tmo == '0) begin
          timeout = 1'b1;
        end
      end
      PARITY: begin
        if (fall)             state_n = STOP;
        else if (tmo == '0)   timeout = 1'b1;
      end
      STOP: begin
        if (fall) begin
          frame_done = 1'b1;
          state_n    = IDLE;
        end else if (tmo == '0) begin
          timeout = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (timeout) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tmo        <= TMO_RELOAD;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;

      if (state == IDLE || fall) tmo <= TMO_RELOAD;
      else if (tmo != '0)        tmo <= tmo - 1'b1;

      if (state == IDLE && fall) bit_cnt <= '0;

      if (state == DATA && fall) begin
        shreg[bit_cnt] <= data_s;
        bit_cnt        <= bit_cnt + 1'b1;
      end

      if (state == PARITY && fall) par_bit <= data_s;

      if (frame_done) begin
        if (par_ok && stop_ok) begin
          byte_out   <= shreg;
          byte_valid <= 1'b1;
        end else begin
          parity_err <= ~par_ok;
          frame_err  <= ~stop_ok;
        end
      end

      if (timeout) begin
        frame_err <= 1'b1;
        shreg     <= '0;
        bit_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_deserializer.sv
// Randomized + directed scoreboard bench for ps2_rx_deserializer.
// Latency: n/a.
// Backpressure: n/a.
module tb_ps2_rx_deserializer;

  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       parity_err;
  logic       frame_err;

  ps2_rx_deserializer dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] flags;     // {byte_valid, parity_err, frame_err}
    logic [7:0] byte_out;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is good when the ones-count of data+parity is odd and stop is 1.
  task automatic expect_frame(input logic [7:0] d, input logic p, input logic s);
    exp_t e;
    bit   par_good;
    par_good = (($countones(d) + int'(p)) % 2) == 1;
    if (par_good && s) begin
      last_good = d;
      e.flags   = 3'b100;
    end else begin
      e.flags = {1'b0, !par_good, !s};
    end
    e.byte_out = last_good;
    exp_q.push_back(e);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends the first nbits bits of {stop, parity, data, start}; data changes while ps2_clk is high.
  task automatic send_bits(input logic [7:0] d, input logic p, input logic s, input int nbits);
    logic [10:0] frame;
    frame = {s, p, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      wait_clks(HALF);
      ps2_clk = 1'b0;
      wait_clks(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    expect_frame(d, p, s);
    send_bits(d, p, s, 11);
  endtask

  task automatic drain;
    int budget;
    budget = 2000;
    while (exp_q.size() != 0 && budget > 0) begin
      wait_clks(1);
      budget--;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every strobe cycle is matched against the next expected outcome.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (byte_valid || parity_err || frame_err)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got bv=%0b pe=%0b fe=%0b expected none at %0t",
                 byte_valid, parity_err, frame_err, $time);
      end else begin
        e = exp_q.pop_front();
        check("strobe_flags", 32'({byte_valid, parity_err, frame_err}), 32'(e.flags));
        check("byte_out", 32'(byte_out), 32'(e.byte_out));
      end
    end
  end

  initial begin
    logic [7:0] rd;
    logic       rp;
    logic       rs;

    wait_clks(5);
    check("reset_byte_out", 32'(byte_out), 32'd0);
    check("reset_strobes", 32'({byte_valid, parity_err, frame_err}), 32'd0);
    reset = 1'b0;
    wait_clks(100);

    // Single good frame
    send_frame(8'h08, 1'b0, 1'b1);
    drain();

    // Back-to-back good frames
    send_frame(8'h09, 1'b1, 1'b1);
    send_frame(8'h05, 1'b1, 1'b1);
    send_frame(8'hFA, 1'b1, 1'b1);
    drain();

    // Bad parity, then bad stop bit
    send_frame(8'h08, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b0);
    drain();

    // Timeout after start + 4 data bits
    exp_q.push_back(exp_t'({3'b001, last_good}));
    send_bits(8'h0A, 1'b0, 1'b1, 5);
    wait_clks(5100);
    drain();
    send_frame(8'h3C, 1'b1, 1'b1);
    drain();

    // Short glitches on ps2_clk in IDLE must be filtered out
    for (int g = 1; g <= 3; g++) begin
      ps2_clk = 1'b0;
      wait_clks(g);
      ps2_clk = 1'b1;
      wait_clks(50);
    end
    check("glitch_no_pending", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a frame (after data bit 3)
    send_bits(8'hA7, 1'b0, 1'b1, 5);
    reset = 1'b1;
    wait_clks(3);
    check("midreset_byte_out", 32'(byte_out), 32'd0);
    check("midreset_strobes", 32'({byte_valid, parity_err, frame_err}), 32'd0);
    last_good = 8'h00;
    reset = 1'b0;
    wait_clks(100);
    send_frame(8'h55, 1'b1, 1'b1);
    drain();

    // Random frames: random byte, random parity, stop mostly good
    for (int k = 0; k < 20; k++) begin
      rd = 8'($urandom_range(0, 255));
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rd, rp, rs);
    end
    drain();

    wait_clks(200);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
